lcd_rect_fill_engine: RTL and testbench

//  Parametrised successor to the single-span LCD drawing controller: fills clipped rectangles (or the full screen) with a solid colour.

---
 rtl/lcd_rect_fill_engine_pkg.sv | 31 +++
 rtl/lcd_rect_fill_engine_if.sv | 37 +++
 rtl/lcd_rect_fill_engine_span_writer.sv | 111 +++++++++++
 rtl/lcd_rect_fill_engine.sv | 186 ++++++++++++++++++
 tb/tb_lcd_rect_fill_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_rect_fill_engine_pkg.sv
// Shared definitions for the LCD rectangle fill engine.
//   - default geometry / bus widths (display size, coordinate and address widths)
//   - FSM state encodings for the command controller and the row span writer
package lcd_rect_fill_engine_pkg;

  localparam int H_DISP_DEF   = 1024;
  localparam int V_DISP_DEF   = 768;
  localparam int PIX_W_DEF    = 24;
  localparam int COORD_W_DEF  = 16;
  localparam int ADDR_W_DEF   = 32;
  localparam int LOAD_GAP_DEF = 4;

  // Command-level FSM. ENG_SPAN covers LOAD/SETTLE/WRITE of one row, which
  // the span writer sequences on its own.
  typedef enum logic [2:0] {
    ENG_IDLE = 3'd0,
    ENG_CALC = 3'd1,
    ENG_SPAN = 3'd2,
    ENG_NEXT = 3'd3,
    ENG_DONE = 3'd4
  } eng_state_e;

  // Row-level FSM inside the span writer.
  typedef enum logic [1:0] {
    SPAN_IDLE   = 2'd0,
    SPAN_LOAD   = 2'd1,
    SPAN_SETTLE = 2'd2,
    SPAN_WRITE  = 2'd3
  } span_state_e;

endpackage

// File: rtl/lcd_rect_fill_engine_if.sv
// Write-port bundle between the fill engine and the SDRAM controller write side.
//   sys_wr_ready  controller -> engine  write FIFO can take a word this cycle
//   sys_load      engine -> controller  one-cycle write-window load / FIFO clear
//   sys_addr_min  engine -> controller  row window start address
//   sys_addr_max  engine -> controller  row window end address (exclusive)
//   sys_we        engine -> controller  write strobe for sys_data
//   sys_data      engine -> controller  pixel word
// Modports: master = engine side, slave = controller side.
interface lcd_rect_fill_engine_if #(
  parameter int ADDR_W = lcd_rect_fill_engine_pkg::ADDR_W_DEF,
  parameter int PIX_W  = lcd_rect_fill_engine_pkg::PIX_W_DEF
);
  logic              sys_wr_ready;
  logic              sys_load;
  logic [ADDR_W-1:0] sys_addr_min;
  logic [ADDR_W-1:0] sys_addr_max;
  logic              sys_we;
  logic [PIX_W-1:0]  sys_data;

  modport master (
    input  sys_wr_ready,
    output sys_load,
    output sys_addr_min,
    output sys_addr_max,
    output sys_we,
    output sys_data
  );

  modport slave (
    output sys_wr_ready,
    input  sys_load,
    input  sys_addr_min,
    input  sys_addr_max,
    input  sys_we,
    input  sys_data
  );
endinterface

// File: rtl/lcd_rect_fill_engine_span_writer.sv
// Row span writer: given a start pulse, emits one write-window load for
// [base, base+len), waits LOAD_GAP idle cycles for the controller to reload
// its address registers, then streams len copies of pixel under FIFO
// backpressure. done pulses in the cycle of the last write.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a row (only honoured while idle)
//   base, len, pixel        row start address, row length (>=1), colour
//   wr_ready                write FIFO has room
//   load, addr_min/addr_max window load strobe and window bounds
//   we, data                write strobe and pixel word
//   done                    last word of the row written this cycle
// LOAD_GAP must be below 256.
module lcd_rect_fill_engine_span_writer
  import lcd_rect_fill_engine_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int LOAD_GAP = LOAD_GAP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base,
  input  logic [COORD_W-1:0] len,
  input  logic [PIX_W-1:0]   pixel,
  input  logic               wr_ready,
  output logic               load,
  output logic [ADDR_W-1:0]  addr_min,
  output logic [ADDR_W-1:0]  addr_max,
  output logic               we,
  output logic [PIX_W-1:0]   data,
  output logic               done
);

  localparam logic [7:0] GAP_LAST = 8'((LOAD_GAP > 0) ? (LOAD_GAP - 1) : 0);

  span_state_e        state_q, state_d;
  logic [7:0]         gap_q, gap_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0]  amin_q, amin_d;
  logic [ADDR_W-1:0]  amax_q, amax_d;

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    col_d    = col_q;
    amin_d   = amin_q;
    amax_d   = amax_q;
    load     = 1'b0;
    we       = 1'b0;
    data     = '0;
    done     = 1'b0;
    // Window bounds hold their last loaded value; during LOAD they show the
    // new window in the same cycle as the load strobe.
    addr_min = amin_q;
    addr_max = amax_q;

    unique case (state_q)
      SPAN_IDLE: begin
        if (start) state_d = SPAN_LOAD;
      end
      SPAN_LOAD: begin
        load     = 1'b1;
        addr_min = base;
        addr_max = base + ADDR_W'(len);
        amin_d   = addr_min;
        amax_d   = addr_max;
        gap_d    = '0;
        col_d    = '0;
        state_d  = (LOAD_GAP == 0) ? SPAN_WRITE : SPAN_SETTLE;
      end
      SPAN_SETTLE: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) state_d = SPAN_WRITE;
      end
      SPAN_WRITE: begin
        data = pixel;
        // Backpressure freezes the column counter; a word is only consumed
        // when the strobe actually fires.
        if (wr_ready) begin
          we    = 1'b1;
          col_d = col_q + COORD_W'(1);
          if (col_q == len - COORD_W'(1)) begin
            done    = 1'b1;
            state_d = SPAN_IDLE;
          end
        end
      end
      default: state_d = SPAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SPAN_IDLE;
      gap_q   <= '0;
      col_q   <= '0;
      amin_q  <= '0;
      amax_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      col_q   <= col_d;
      amin_q  <= amin_d;
      amax_q  <= amax_d;
    end
  end

endmodule

// File: rtl/lcd_rect_fill_engine.sv
// LCD rectangle fill engine: accepts a fill command (clipped rectangle or
// full-screen clear) and drives the SDRAM controller write port row by row.
// Frame buffer is linear: addr = y*H_DISP + x, one word per pixel.
// Ports:
//   clk, rst_n                 clock (clk_ref domain), async active-low reset
//   sys_vaild                  SDRAM init done; commands accepted only while high
//   enable                     command strobe, sampled while not busy
//   mode                       0 = rectangle fill, 1 = full-screen clear
//   x_pos, y_pos, width, height rectangle geometry
//   pixel                      fill colour
//   busy                       command in progress
//   done                       one-cycle pulse when a command retires
//   wr                         write-port bundle (master side)
module lcd_rect_fill_engine
  import lcd_rect_fill_engine_pkg::*;
#(
  parameter int H_DISP   = H_DISP_DEF,
  parameter int V_DISP   = V_DISP_DEF,
  parameter int PIX_W    = PIX_W_DEF,
  parameter int COORD_W  = COORD_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LOAD_GAP = LOAD_GAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sys_vaild,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [COORD_W-1:0]     x_pos,
  input  logic [COORD_W-1:0]     y_pos,
  input  logic [COORD_W-1:0]     width,
  input  logic [COORD_W-1:0]     height,
  input  logic [PIX_W-1:0]       pixel,
  output logic                   busy,
  output logic                   done,
  lcd_rect_fill_engine_if.master wr
);

  eng_state_e         state_q, state_d;
  logic               mode_q, mode_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [COORD_W-1:0] w_q, w_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [COORD_W-1:0] w_eff_q, w_eff_d;
  logic [COORD_W-1:0] h_eff_q, h_eff_d;
  logic [COORD_W-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;

  logic               span_start;
  logic               span_done;

  // Clipping terms, evaluated from the latched command during CALC.
  logic [ADDR_W-1:0]  avail_x, avail_y;
  logic               off_screen, empty_rect, noop;
  logic [COORD_W-1:0] w_clip, h_clip;
  logic [ADDR_W-1:0]  base_calc;

  always_comb begin
    avail_x    = ADDR_W'(H_DISP) - ADDR_W'(x_q);
    avail_y    = ADDR_W'(V_DISP) - ADDR_W'(y_q);
    off_screen = (ADDR_W'(x_q) >= ADDR_W'(H_DISP)) || (ADDR_W'(y_q) >= ADDR_W'(V_DISP));
    empty_rect = (w_q == '0) || (h_q == '0);
    noop       = !mode_q && (off_screen || empty_rect);
    // avail_x/avail_y are only meaningful when the origin is on screen;
    // off-screen commands take the no-op path and never use them.
    w_clip     = (ADDR_W'(w_q) > avail_x) ? COORD_W'(avail_x) : w_q;
    h_clip     = (ADDR_W'(h_q) > avail_y) ? COORD_W'(avail_y) : h_q;
    // Single multiply per command; later rows advance by addition in NEXT.
    base_calc  = mode_q ? '0 : (ADDR_W'(y_q) * ADDR_W'(H_DISP) + ADDR_W'(x_q));
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    pix_d      = pix_q;
    w_eff_d    = w_eff_q;
    h_eff_d    = h_eff_q;
    row_cnt_d  = row_cnt_q;
    row_base_d = row_base_q;
    span_start = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ENG_IDLE);

    unique case (state_q)
      ENG_IDLE: begin
        // Strobes arriving while busy or before SDRAM init are dropped.
        if (enable && sys_vaild) begin
          mode_d  = mode;
          x_d     = x_pos;
          y_d     = y_pos;
          w_d     = width;
          h_d     = height;
          pix_d   = pixel;
          state_d = ENG_CALC;
        end
      end
      ENG_CALC: begin
        w_eff_d    = mode_q ? COORD_W'(H_DISP) : w_clip;
        h_eff_d    = mode_q ? COORD_W'(V_DISP) : h_clip;
        row_base_d = base_calc;
        row_cnt_d  = '0;
        if (noop) begin
          state_d = ENG_DONE;
        end else begin
          // Span writer enters LOAD next cycle, when row_base_q is valid.
          span_start = 1'b1;
          state_d    = ENG_SPAN;
        end
      end
      ENG_SPAN: begin
        if (span_done) state_d = ENG_NEXT;
      end
      ENG_NEXT: begin
        row_base_d = row_base_q + ADDR_W'(H_DISP);
        row_cnt_d  = row_cnt_q + COORD_W'(1);
        if ((row_cnt_q + COORD_W'(1)) == h_eff_q) begin
          state_d = ENG_DONE;
        end else begin
          span_start = 1'b1;
          state_d    = ENG_SPAN;
        end
      end
      ENG_DONE: begin
        done    = 1'b1;
        state_d = ENG_IDLE;
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENG_IDLE;
      mode_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      pix_q      <= '0;
      w_eff_q    <= '0;
      h_eff_q    <= '0;
      row_cnt_q  <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      pix_q      <= pix_d;
      w_eff_q    <= w_eff_d;
      h_eff_q    <= h_eff_d;
      row_cnt_q  <= row_cnt_d;
      row_base_q <= row_base_d;
    end
  end

  lcd_rect_fill_engine_span_writer #(
    .ADDR_W   (ADDR_W),
    .PIX_W    (PIX_W),
    .COORD_W  (COORD_W),
    .LOAD_GAP (LOAD_GAP)
  ) u_span (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (span_start),
    .base     (row_base_q),
    .len      (w_eff_q),
    .pixel    (pix_q),
    .wr_ready (wr.sys_wr_ready),
    .load     (wr.sys_load),
    .addr_min (wr.sys_addr_min),
    .addr_max (wr.sys_addr_max),
    .we       (wr.sys_we),
    .data     (wr.sys_data),
    .done     (span_done)
  );

endmodule

// File: tb/tb_lcd_rect_fill_engine.sv
// Testbench for lcd_rect_fill_engine on a reduced 64x32 screen so that a
// full-screen clear stays short. Stimulus pushes expected window loads,
// pixel writes and done pulses into queues; a monitor pops and compares
// whenever the DUT strobes sys_load, sys_we or done.
module tb_lcd_rect_fill_engine;

  localparam int H   = 64;
  localparam int V   = 32;
  localparam int PW  = 24;
  localparam int CW  = 16;
  localparam int AW  = 32;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_vaild = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] x_pos = '0, y_pos = '0, width = '0, height = '0;
  logic [PW-1:0] pixel = '0;
  logic          busy, done;

  lcd_rect_fill_engine_if #(.ADDR_W(AW), .PIX_W(PW)) wr_if ();

  lcd_rect_fill_engine #(
    .H_DISP(H), .V_DISP(V), .PIX_W(PW), .COORD_W(CW), .ADDR_W(AW), .LOAD_GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sys_vaild(sys_vaild), .enable(enable), .mode(mode),
    .x_pos(x_pos), .y_pos(y_pos), .width(width), .height(height), .pixel(pixel),
    .busy(busy), .done(done), .wr(wr_if)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] lo; logic [AW-1:0] hi; } win_t;
  typedef struct packed { logic [AW-1:0] addr; logic [PW-1:0] data; } wr_t;

  win_t          load_q[$];
  wr_t           wr_q[$];
  int            done_pend = 0;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            issue_cyc = 0;
  bit            lat_armed = 1'b0;
  int            ready_mode = 0;
  logic [AW-1:0] cur_min = '0;
  int            off = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic void flag(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endfunction

  // Ready generator: 0 = always ready, 1 = random, 2 = toggles every 3 cycles.
  initial begin
    int ph;
    ph = 0;
    wr_if.sys_wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph++;
      case (ready_mode)
        0: wr_if.sys_wr_ready = 1'b1;
        1: wr_if.sys_wr_ready = ($urandom_range(0, 3) != 0);
        default: wr_if.sys_wr_ready = ((ph / 3) % 2) == 0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    win_t ew;
    wr_t  ee;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_if.sys_load) begin
          if (load_q.size() == 0) flag("unexpected_load", wr_if.sys_addr_min, 0);
          else begin
            ew = load_q.pop_front();
            check("load_min", wr_if.sys_addr_min, ew.lo);
            check("load_max", wr_if.sys_addr_max, ew.hi);
          end
          cur_min = wr_if.sys_addr_min;
          off = 0;
        end
        if (wr_if.sys_we) begin
          check("we_needs_ready", wr_if.sys_wr_ready, 1);
          if (wr_q.size() == 0) flag("unexpected_write", wr_if.sys_data, 0);
          else begin
            ee = wr_q.pop_front();
            check("wr_addr", cur_min + AW'(off), ee.addr);
            check("wr_data", wr_if.sys_data, ee.data);
          end
          off++;
          if (lat_armed) begin
            check("latency", cyc - issue_cyc, 3 + GAP);
            lat_armed = 1'b0;
          end
        end
        if (done) begin
          if (done_pend == 0) flag("unexpected_done", 1, 0);
          else begin
            check("done_expected", done_pend > 0, 1);
            done_pend--;
          end
        end
      end
    end
  end

  // Reference model: rows, windows and words from the clipping rules.
  task automatic model(input bit m, input int x, input int y, input int w, input int h,
                       input logic [PW-1:0] pix, output bit noop);
    int x0, y0, we, he;
    noop = 1'b0; x0 = 0; y0 = 0; we = 0; he = 0;
    if (m) begin
      we = H; he = V;
    end else if (x >= H || y >= V || w == 0 || h == 0) begin
      noop = 1'b1;
    end else begin
      x0 = x; y0 = y;
      we = (w < H - x) ? w : H - x;
      he = (h < V - y) ? h : V - y;
    end
    for (int r = 0; r < he; r++) begin
      win_t wv;
      wv.lo = AW'((y0 + r) * H + x0);
      wv.hi = wv.lo + AW'(we);
      load_q.push_back(wv);
      for (int c = 0; c < we; c++) begin
        wr_t e;
        e.addr = wv.lo + AW'(c);
        e.data = pix;
        wr_q.push_back(e);
      end
    end
    done_pend++;
  endtask

  task automatic drive_cmd(input bit m, input int x, input int y, input int w, input int h,
                           input logic [PW-1:0] pix);
    mode = m; x_pos = CW'(x); y_pos = CW'(y); width = CW'(w); height = CW'(h);
    pixel = pix; enable = 1'b1;
  endtask

  // Issue a command once the engine is idle; the model is updated only when
  // sys_vaild makes the command acceptable.
  task automatic issue(input bit m, input int x, input int y, input int w, input int h,
                       input logic [PW-1:0] pix);
    int n;
    bit noop;
    n = 0;
    while (busy && n < 20000) begin @(posedge clk); #1; n++; end
    if (n >= 20000) flag("idle_wait_timeout", n, 0);
    drive_cmd(m, x, y, w, h, pix);
    if (sys_vaild) begin
      model(m, x, y, w, h, pix, noop);
      issue_cyc = cyc;
      lat_armed = (ready_mode == 0) && !noop;
    end
    @(posedge clk); #1;
    enable = 1'b0;
    check(sys_vaild ? "busy_after_accept" : "busy_stays_low", busy, sys_vaild);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || done_pend != 0) && n < budget) begin @(posedge clk); #1; n++; end
    check("cmd_finished_in_budget", n < budget, 1);
    check("loads_left", load_q.size(), 0);
    check("writes_left", wr_q.size(), 0);
    check("done_left", done_pend, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load"}, wr_if.sys_load, 0);
    check({tag, "_we"}, wr_if.sys_we, 0);
    check({tag, "_amin"}, wr_if.sys_addr_min, 0);
    check({tag, "_amax"}, wr_if.sys_addr_max, 0);
    check({tag, "_data"}, wr_if.sys_data, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Enable before SDRAM init is ignored.
    issue(0, 1, 1, 4, 2, 24'h111111);
    repeat (5) @(posedge clk);
    #1;
    check("no_cmd_without_vaild", busy, 0);
    sys_vaild = 1'b1;

    // Basic rectangle.
    ready_mode = 0;
    issue(0, 10, 2, 4, 3, 24'hA5C3E1);
    wait_idle(2000);

    // Clipping on both right and bottom edges.
    issue(0, H - 4, V - 2, 10, 5, 24'h0F0F0F);
    wait_idle(2000);

    // Backpressure toggling every three cycles.
    ready_mode = 2;
    issue(0, 3, 5, 20, 3, 24'h123456);
    wait_idle(4000);

    // Full-screen clear ignores geometry.
    ready_mode = 0;
    issue(1, 500, 700, 0, 0, 24'hFFFFFF);
    wait_idle(20000);

    // Degenerate commands retire with done only.
    issue(0, 5, 5, 0, 3, 24'h010203);
    wait_idle(200);
    issue(0, 2000, 1, 4, 4, 24'h040506);
    wait_idle(200);
    issue(0, 1, V, 4, 4, 24'h070809);
    wait_idle(200);
    issue(0, 1, 1, 4, 0, 24'h0A0B0C);
    wait_idle(200);

    // Enable while busy is dropped.
    issue(0, 0, 0, 30, 3, 24'h336699);
    repeat (3) @(posedge clk);
    #1;
    drive_cmd(0, 2, 2, 5, 5, 24'hDEAD00);
    @(posedge clk); #1;
    enable = 1'b0;
    check("busy_during_ignored_enable", busy, 1);
    wait_idle(2000);

    // Asynchronous reset in the middle of a row.
    issue(0, 0, 0, 40, 4, 24'h55AA55);
    n = 0;
    while (!wr_if.sys_we && n < 200) begin @(negedge clk); n++; end
    check("reached_write", wr_if.sys_we, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    load_q.delete();
    wr_q.delete();
    done_pend = 0;
    lat_armed = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", busy, 0);
    issue(0, 7, 9, 6, 2, 24'h777777);
    wait_idle(2000);

    // Randomized commands.
    for (int i = 0; i < 30; i++) begin
      bit m;
      ready_mode = $urandom_range(0, 2);
      m = ($urandom_range(0, 9) == 0);
      issue(m, $urandom_range(0, H + 8), $urandom_range(0, V + 4),
            $urandom_range(0, 20), $urandom_range(0, 6), PW'($urandom));
      wait_idle(20000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
